max_stream_reduce: RTL and testbench

- Streaming, multi-lane, parametrised running-max/argmax unit. Successor to the combinational approximate max blocks in the MHD flow.
- Consumes frames of LANES unsigned samples per beat over a valid/ready stream. Emits one result per frame: maximum value, its global index, and the frame sample count.
- Runtime-selectable approximate compare drops APPROX_LSB low bits from the comparison, so the exact/approximate accuracy trade-off can be measured in-system.

---
 rtl/max_pkg.sv | 34 +++
 rtl/max_lane_tree.sv | 27 ++
 rtl/max_stream_reduce.sv | 146 ++++++++++++++
 tb/tb_max_stream_reduce.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pkg.sv
// Shared types and compare helpers for the streaming max/argmax reducer.
// Candidate fields are sized for the widest supported configuration (WIDTH, IDX_W <= 32).
package max_pkg;

  localparam int CW = 32;
  localparam int CI = 32;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  typedef struct packed {
    logic [CW-1:0] value;
    logic [CI-1:0] idx;
    logic          valid;
  } cand_t;

  function automatic logic [CW-1:0] key_of(input logic [CW-1:0] value,
                                           input logic          approx_en,
                                           input int unsigned   lsb);
    return approx_en ? (value >> lsb) : value;
  endfunction

  // True when a should replace b: strictly larger key, or equal key at an earlier index.
  function automatic logic better(input cand_t       a,
                                  input cand_t       b,
                                  input logic        approx_en,
                                  input int unsigned lsb);
    logic [CW-1:0] ka;
    logic [CW-1:0] kb;
    ka = key_of(a.value, approx_en, lsb);
    kb = key_of(b.value, approx_en, lsb);
    return a.valid && (!b.valid || (ka > kb) || ((ka == kb) && (a.idx < b.idx)));
  endfunction

endpackage

// File: rtl/max_lane_tree.sv
// Combinational binary reduction of one beat's lane candidates into the best candidate.
// Heap layout: leaves hold lanes in order, so the left child is always the lower lane.
module max_lane_tree
  import max_pkg::*;
#(
  parameter int          LANES      = 4,
  parameter int unsigned APPROX_LSB = 4
) (
  input  logic  approx_en,
  input  cand_t cands [LANES],
  output cand_t best
);

  cand_t node [2*LANES-1];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      node[LANES-1+k] = cands[k];
    end
    for (int i = LANES - 2; i >= 0; i--) begin
      node[i] = better(node[2*i+2], node[2*i+1], approx_en, APPROX_LSB) ?
                node[2*i+2] : node[2*i+1];
    end
    best = node[0];
  end

endmodule

// File: rtl/max_stream_reduce.sv
// Streaming multi-lane running max/argmax with optional approximate compare.
// One result per frame: winning value, global index, kept-sample count, empty/overflow flags.
module max_stream_reduce
  import max_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          LANES      = 4,
  parameter int          IDX_W      = 16,
  parameter int unsigned APPROX_LSB = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_approx_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_keep,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_max,
  output logic [IDX_W-1:0]       out_idx,
  output logic [IDX_W-1:0]       out_count,
  output logic                   out_empty,
  output logic                   out_ovf
);

  localparam int unsigned     IDX_MAX    = (1 << IDX_W) - 1;
  localparam int unsigned     BEAT_MAX   = IDX_MAX / LANES;
  localparam logic [IDX_W:0]  BEAT_MAX_W = (IDX_W+1)'(BEAT_MAX);
  localparam logic [IDX_W:0]  BEAT_SAT   = (IDX_W+1)'(BEAT_MAX + 1);
  localparam logic [IDX_W:0]  BEAT_ONE   = (IDX_W+1)'(1);

  state_t state, state_nx;

  cand_t            acc;
  logic [IDX_W:0]   beat_cnt;
  logic [IDX_W-1:0] acc_cnt;
  logic             approx_q;
  logic             ovf_q;

  logic             accept;
  logic             first;
  logic             approx_eff;
  logic [IDX_W:0]   bn;
  logic             beat_ovf;
  logic [IDX_W-1:0] cur_beat;
  logic [31:0]      pop;
  logic [31:0]      cnt_sum;
  logic             cnt_ovf;
  logic [IDX_W-1:0] cnt_sat;
  logic             ovf_nx;
  cand_t            lanes [LANES];
  cand_t            beat_best;
  cand_t            merged;

  // Handshake: a beat moves on in_valid & in_ready, a result on out_valid & out_ready.
  // While a result is held, a new beat is taken only in the cycle that result is consumed.
  assign in_ready  = (state != HOLD) | out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  always_comb begin
    first      = (state != ACC);
    approx_eff = first ? cfg_approx_en : approx_q;
    bn         = first ? '0 : beat_cnt;
    beat_ovf   = (bn > BEAT_MAX_W);
    cur_beat   = beat_ovf ? BEAT_MAX_W[IDX_W-1:0] : bn[IDX_W-1:0];
    pop        = '0;
    for (int k = 0; k < LANES; k++) begin
      lanes[k].value = CW'(in_data[k*WIDTH +: WIDTH]);
      lanes[k].idx   = CI'(IDX_W'(32'(cur_beat) * LANES + k));
      lanes[k].valid = in_keep[k];
      pop            = pop + 32'(in_keep[k]);
    end
  end

  max_lane_tree #(
    .LANES      (LANES),
    .APPROX_LSB (APPROX_LSB)
  ) u_tree (
    .approx_en (approx_eff),
    .cands     (lanes),
    .best      (beat_best)
  );

  always_comb begin
    if (first) begin
      merged = beat_best;
    end else begin
      merged = better(beat_best, acc, approx_eff, APPROX_LSB) ? beat_best : acc;
    end
    cnt_sum = (first ? 32'd0 : 32'(acc_cnt)) + pop;
    cnt_ovf = (cnt_sum > IDX_MAX);
    cnt_sat = cnt_ovf ? '1 : cnt_sum[IDX_W-1:0];
    ovf_nx  = (first ? 1'b0 : ovf_q) | beat_ovf | cnt_ovf;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, ACC: begin
        if (accept) state_nx = in_last ? HOLD : ACC;
      end
      HOLD: begin
        if (accept)         state_nx = in_last ? HOLD : ACC;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      beat_cnt  <= '0;
      acc_cnt   <= '0;
      approx_q  <= 1'b0;
      ovf_q     <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      out_count <= '0;
      out_empty <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc      <= merged;
        acc_cnt  <= cnt_sat;
        approx_q <= approx_eff;
        ovf_q    <= ovf_nx;
        beat_cnt <= (bn == BEAT_SAT) ? bn : bn + BEAT_ONE;
        // Results live in their own registers so the next frame can load acc during HOLD.
        if (in_last) begin
          out_max   <= merged.valid ? merged.value[WIDTH-1:0] : '0;
          out_idx   <= merged.valid ? merged.idx[IDX_W-1:0] : '1;
          out_count <= cnt_sat;
          out_empty <= ~merged.valid;
          out_ovf   <= ovf_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_stream_reduce.sv
// Bench for max_stream_reduce: vector table, hand-written corner sequences and random frames.
module tb_max_stream_reduce;

  typedef struct packed {
    logic [15:0] max;
    logic [15:0] idx;
    logic [15:0] count;
    logic        empty;
    logic        ovf;
  } res_t;

  typedef struct {
    int              nb;
    logic            approx;
    logic [7:0][63:0] data;
    logic [7:0][3:0]  keep;
    res_t            exp;
  } vec_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (WIDTH=16, LANES=4, IDX_W=16)
  logic        cfg_approx_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [3:0]  in_keep = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_max;
  logic [15:0] out_idx;
  logic [15:0] out_count;
  logic        out_empty;
  logic        out_ovf;

  max_stream_reduce #(.WIDTH(16), .LANES(4), .IDX_W(16), .APPROX_LSB(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_approx_en(cfg_approx_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_count(out_count), .out_empty(out_empty), .out_ovf(out_ovf)
  );

  // small-index instance (IDX_W=4) for saturation
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [63:0] s_in_data = '0;
  logic [3:0]  s_in_keep = '0;
  logic        s_in_last = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [15:0] s_out_max;
  logic [3:0]  s_out_idx;
  logic [3:0]  s_out_count;
  logic        s_out_empty;
  logic        s_out_ovf;
  logic        s_cfg = 1'b0;

  max_stream_reduce #(.WIDTH(16), .LANES(4), .IDX_W(4), .APPROX_LSB(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .cfg_approx_en(s_cfg),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_keep(s_in_keep),
    .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_max(s_out_max),
    .out_idx(s_out_idx), .out_count(s_out_count), .out_empty(s_out_empty), .out_ovf(s_out_ovf)
  );

  // scoreboard state
  logic [49:0] exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   stalls  = 0;
  logic rand_ready = 1'b0;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [63:0] beat(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic res_t mkres(input logic [15:0] m, input logic [15:0] i,
                                 input logic [15:0] c, input logic e, input logic o);
    res_t r;
    r.max = m; r.idx = i; r.count = c; r.empty = e; r.ovf = o;
    return r;
  endfunction

  function automatic vec_t blank(input int nb, input logic approx);
    vec_t v;
    v.nb = nb; v.approx = approx; v.data = '0; v.keep = '0; v.exp = '0;
    return v;
  endfunction

  // Reference: scan kept samples in index order, replace only on strictly larger key.
  function automatic res_t model(input vec_t v);
    res_t        r;
    int          cnt;
    int          bi;
    bit          found;
    logic [15:0] s;
    logic [15:0] key;
    logic [15:0] bk;
    logic [15:0] bv;
    cnt = 0; bi = 0; found = 0; bk = '0; bv = '0;
    for (int b = 0; b < v.nb; b++) begin
      for (int k = 0; k < 4; k++) begin
        if (v.keep[b][k]) begin
          s   = v.data[b][k*16 +: 16];
          key = v.approx ? (s >> 4) : s;
          cnt++;
          if (!found || key > bk) begin
            found = 1; bk = key; bv = s; bi = b * 4 + k;
          end
        end
      end
    end
    r.max   = found ? bv : 16'h0;
    r.idx   = found ? 16'(bi) : 16'hFFFF;
    r.count = 16'(cnt);
    r.empty = !found;
    r.ovf   = 1'b0;
    return r;
  endfunction

  // driver tasks
  task automatic wait_accept();
    int n;
    n = 0;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        fail_now("accept_timeout");
        break;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    stalls += n;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input vec_t v);
    for (int b = 0; b < v.nb; b++) begin
      in_valid      = 1'b1;
      in_data       = v.data[b];
      in_keep       = v.keep[b];
      in_last       = (b == v.nb - 1);
      cfg_approx_en = (b == 0) ? v.approx : ~v.approx;
      if (b == v.nb - 1) exp_q.push_back(v.exp);
      wait_accept();
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_keep  = 4'($urandom_range(0, 15));
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic small_frame(input int nb, input int mb, input int ml);
    logic [63:0] d;
    int n;
    int ei;
    int ec;
    logic eo;
    for (int b = 0; b < nb; b++) begin
      d = {4{16'h0010}};
      if (b == mb) d[ml*16 +: 16] = 16'h00FF;
      s_in_valid = 1'b1;
      s_in_data  = d;
      s_in_keep  = 4'hF;
      s_in_last  = (b == nb - 1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s_out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!s_out_valid) fail_now("small_out_valid");
    ei = ((mb > 3) ? 3 : mb) * 4 + ml;
    ec = (nb * 4 > 15) ? 15 : nb * 4;
    eo = (nb > 4) || (nb * 4 > 15);
    check("small_max",   64'(s_out_max),   64'h00FF);
    check("small_idx",   64'(s_out_idx),   64'(ei));
    check("small_count", 64'(s_out_count), 64'(ec));
    check("small_ovf",   64'(s_out_ovf),   64'(eo));
    check("small_empty", 64'(s_out_empty), 64'd0);
    @(posedge clk); #1;
  endtask

  // result monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        check("result", 64'({out_max, out_idx, out_count, out_empty, out_ovf}),
              64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t bp;
    vec_t rv;

    v = blank(1, 0); v.data[0] = beat(16'h0010, 16'h0300, 16'h0200, 16'h0300); v.keep[0] = 4'hF;
    v.exp = mkres(16'h0300, 16'd1, 16'd4, 0, 0); tbl[0] = v;
    v = blank(2, 1); v.data[0] = beat(16'h0105, 16'h010F, 0, 0); v.data[1] = beat(16'h0100, 0, 0, 0);
    v.keep[0] = 4'hF; v.keep[1] = 4'hF; v.exp = mkres(16'h0105, 16'd0, 16'd8, 0, 0); tbl[1] = v;
    v.approx = 0; v.exp = mkres(16'h010F, 16'd1, 16'd8, 0, 0); tbl[2] = v;
    v = blank(4, 0);
    for (int b = 0; b < 3; b++) v.data[b] = beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    v.data[3] = beat(16'hFFFF, 16'hFFFF, 16'h0007, 16'hFFFF); v.keep[3] = 4'b0100;
    v.exp = mkres(16'h0007, 16'd14, 16'd1, 0, 0); tbl[3] = v;
    v = blank(2, 0); v.data[0] = beat(16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC); v.data[1] = v.data[0];
    v.exp = mkres(16'h0000, 16'hFFFF, 16'd0, 1, 0); tbl[4] = v;
    v = blank(1, 0); v.data[0] = beat(16'h0AAA, 16'h0AAA, 16'h0AAA, 16'h0AAA); v.keep[0] = 4'hF;
    v.exp = mkres(16'h0AAA, 16'd0, 16'd4, 0, 0); tbl[5] = v;
    v = blank(4, 0); v.data[0] = beat(1, 2, 3, 4); v.data[1] = beat(5, 6, 7, 8);
    v.data[2] = beat(9, 10, 11, 12); v.data[3] = beat(13, 14, 15, 16'hFFFF);
    for (int b = 0; b < 4; b++) v.keep[b] = 4'hF;
    v.exp = mkres(16'hFFFF, 16'd15, 16'd16, 0, 0); tbl[6] = v;
    v = blank(3, 1); v.data[0] = beat(16'h00F0, 16'h00F8, 0, 0); v.keep[0] = 4'b0011;
    v.data[1] = beat(16'h00F9, 0, 0, 0); v.keep[1] = 4'b0001;
    v.data[2] = beat(16'h0100, 16'h00FF, 0, 0); v.keep[2] = 4'b0010;
    v.exp = mkres(16'h00F0, 16'd0, 16'd4, 0, 0); tbl[7] = v;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_outputs",   64'({out_max, out_idx, out_count, out_empty, out_ovf}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) drive_frame(tbl[t]);
    drain();

    // back-to-back single-beat frames at full rate
    stalls = 0;
    drive_frame(tbl[0]);
    drive_frame(tbl[5]);
    drive_frame(tbl[0]);
    check("full_rate_stalls", 64'(stalls), 64'd0);
    drain();

    // back-pressure: result held, then consumed in the same cycle a new frame starts
    out_ready = 1'b0;
    bp = blank(1, 0); bp.data[0] = beat(1, 2, 3, 4); bp.keep[0] = 4'hF;
    bp.exp = mkres(16'd4, 16'd3, 16'd4, 0, 0);
    drive_frame(bp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_hold",      64'({out_max, out_idx}), 64'({16'd4, 16'd3}));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_frame(tbl[6]);
    drain();

    // reset mid-frame discards the partial frame
    in_valid = 1'b1; in_data = beat(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    in_keep = 4'hF; in_last = 1'b0;
    wait_accept();
    wait_accept();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = blank(1, 0); rv.data[0] = beat(9, 3, 1, 2); rv.keep[0] = 4'hF;
    rv.exp = mkres(16'd9, 16'd0, 16'd4, 0, 0);
    drive_frame(rv);
    drain();

    // random frames with random back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      v = blank($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      for (int b = 0; b < v.nb; b++) begin
        for (int k = 0; k < 4; k++) begin
          v.data[b][k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                                  16'($urandom_range(0, 40));
        end
        v.keep[b] = 4'($urandom_range(0, 15));
      end
      v.exp = model(v);
      drive_frame(v);
    end
    drain();

    // index/count saturation on the IDX_W=4 instance
    small_frame(5, 4, 3);
    small_frame(2, 1, 2);
    small_frame(4, 3, 1);
    small_frame(3, 2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
